// File: rtl/interrupt_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Holds the dispatch FSM states, the hazard "taken" code and the GIE bit.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_e;

    localparam logic [3:0] HAZ_ACCEPT_DEFAULT = 4'b0010;
    localparam int         GIE_BIT            = 0;

endpackage

// File: rtl/int_priority_encoder.sv
// Fixed-priority encoder: the lowest set request index wins.
// Purely combinational; valid is low when no request is set.
module int_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// N-source vectored interrupt controller with edge/level pending state
// and a request/accept/return handshake towards the hazard unit.
module vectored_interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int         NUM_SRC    = 8,
    parameter int         VEC_W      = 14,
    parameter int         VEC_BASE   = 0,
    parameter logic [3:0] HAZ_ACCEPT = HAZ_ACCEPT_DEFAULT
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [3:0]         hazard_unit_state,
    input  logic               int_return,
    input  logic [7:0]         control_reg,
    input  logic [NUM_SRC-1:0] mask_reg,
    input  logic [NUM_SRC-1:0] mode_reg,
    input  logic [NUM_SRC-1:0] pend_clear,
    output logic               interrupt,
    output logic [VEC_W-1:0]   int_vec_addr,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    irq_state_e         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               irq_q, irq_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;

    logic               gie;
    logic               accept;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] acc_bit;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic               unused_ctrl;

    assign gie         = control_reg[GIE_BIT];
    assign unused_ctrl = ^control_reg;
    assign rise        = int_src & ~src_q;
    assign src_d       = int_src;

    int_priority_encoder #(
        .N     (NUM_SRC),
        .IDX_W (ID_W)
    ) u_prio (
        .req   (pend_q & mask_reg),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gie && win_valid) begin
                    state_d = REQ;
                    id_d    = win_idx;
                    irq_d   = 1'b1;
                    vec_d   = VEC_W'(VEC_BASE) + VEC_W'(win_idx) + VEC_W'(1);
                end
            end
            REQ: begin
                if (!gie) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                    vec_d   = '0;
                end else if (hazard_unit_state == HAZ_ACCEPT) begin
                    state_d = SVC;
                    irq_d   = 1'b0;
                    vec_d   = '0;
                    accept  = 1'b1;
                end
            end
            SVC: begin
                if (int_return) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
                vec_d   = '0;
            end
        endcase
    end

    always_comb begin
        acc_bit = '0;
        pend_d  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            acc_bit[i] = accept && (id_q == ID_W'(i));
            // Edge bits: a new rise beats any clear; level bits track the line.
            if (mode_reg[i]) begin
                pend_d[i] = rise[i] |
                            (pend_q[i] & ~pend_clear[i] & ~acc_bit[i]);
            end else begin
                pend_d[i] = int_src[i];
            end
        end
    end

    // src_q resets low, so a line already high at reset release
    // registers as a rise on the first clock; this is intended.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            id_q    <= '0;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            src_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
        end
    end

    assign interrupt    = irq_q;
    assign int_vec_addr = vec_q;
    assign pending      = pend_q;
    assign in_service   = (state_q == SVC);

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Self-checking bench: directed scenarios plus random traffic
// compared against a behavioural reference model.
module tb_vectored_interrupt_controller;

    localparam logic [3:0] ACC = 4'b0010;

    logic        clock = 1'b0;
    logic        nreset;
    logic [7:0]  int_src;
    logic [3:0]  hazard_unit_state;
    logic        int_return;
    logic [7:0]  control_reg;
    logic [7:0]  mask_reg;
    logic [7:0]  mode_reg;
    logic [7:0]  pend_clear;
    logic        interrupt;
    logic [13:0] int_vec_addr;
    logic [7:0]  pending;
    logic        in_service;

    int checks = 0;
    int errors = 0;

    // Reference model: request id (-1 = none), service flag, pending bits.
    int       m_req;
    bit       m_svc;
    bit [7:0] m_pend;
    bit [7:0] m_last;

    vectored_interrupt_controller dut (
        .clock             (clock),
        .nreset            (nreset),
        .int_src           (int_src),
        .hazard_unit_state (hazard_unit_state),
        .int_return        (int_return),
        .control_reg       (control_reg),
        .mask_reg          (mask_reg),
        .mode_reg          (mode_reg),
        .pend_clear        (pend_clear),
        .interrupt         (interrupt),
        .int_vec_addr      (int_vec_addr),
        .pending           (pending),
        .in_service        (in_service)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req  = -1;
        m_svc  = 0;
        m_pend = '0;
        m_last = '0;
    endtask

    task automatic model_step();
        int acc_id;
        bit gie;
        acc_id = -1;
        gie    = control_reg[0];
        if (m_svc) begin
            if (int_return) m_svc = 0;
        end else if (m_req >= 0) begin
            if (!gie) begin
                m_req = -1;
            end else if (hazard_unit_state == ACC) begin
                acc_id = m_req;
                m_req  = -1;
                m_svc  = 1;
            end
        end else if (gie) begin
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && mask_reg[i]) begin
                    m_req = i;
                    break;
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (!mode_reg[i]) begin
                m_pend[i] = int_src[i];
            end else if (int_src[i] && !m_last[i]) begin
                m_pend[i] = 1;
            end else if (pend_clear[i] || acc_id == i) begin
                m_pend[i] = 0;
            end
        end
        m_last = int_src;
    endtask

    task automatic compare_all();
        check("interrupt", 32'(interrupt), 32'(m_req >= 0));
        check("vector", 32'(int_vec_addr), (m_req >= 0) ? m_req + 1 : 0);
        check("pending", 32'(pending), 32'(m_pend));
        check("in_service", 32'(in_service), 32'(m_svc));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic accept_and_return();
        hazard_unit_state = ACC;
        tick();
        hazard_unit_state = 4'd0;
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
    endtask

    initial begin
        nreset = 1'b0;
        int_src = '0;
        hazard_unit_state = '0;
        int_return = 1'b0;
        control_reg = 8'h01;
        mask_reg = 8'hFF;
        mode_reg = 8'hFF;
        pend_clear = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_irq", 32'(interrupt), 0);
        check("rst_vec", 32'(int_vec_addr), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_svc", 32'(in_service), 0);
        @(negedge clock);
        nreset = 1'b1;

        // Edge source 0: request two clocks after the rise, then accept.
        int_src = 8'h01;
        tick();
        check("s0_pend_k", 32'(pending[0]), 1);
        check("s0_irq_k", 32'(interrupt), 0);
        tick();
        check("s0_irq", 32'(interrupt), 1);
        check("s0_vec", 32'(int_vec_addr), 32'h0001);
        hazard_unit_state = ACC;
        tick();
        hazard_unit_state = 4'd0;
        check("s0_acc_irq", 32'(interrupt), 0);
        check("s0_acc_pend", 32'(pending[0]), 0);
        check("s0_acc_svc", 32'(in_service), 1);
        int_src = 8'h00;
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
        tick();

        // Sources 3 and 5 together: 3 first, 5 after return.
        int_src = 8'h28;
        tick();
        tick();
        check("s35_vec_a", 32'(int_vec_addr), 32'h0004);
        accept_and_return();
        tick();
        check("s35_irq_b", 32'(interrupt), 1);
        check("s35_vec_b", 32'(int_vec_addr), 32'h0006);
        int_src = 8'h00;
        accept_and_return();
        tick();

        // Masked source 2 stays pending until unmasked.
        mask_reg = 8'hFB;
        int_src = 8'h04;
        repeat (3) tick();
        check("m2_irq", 32'(interrupt), 0);
        check("m2_pend", 32'(pending[2]), 1);
        mask_reg = 8'hFF;
        tick();
        check("m2_vec", 32'(int_vec_addr), 32'h0003);
        int_src = 8'h00;
        accept_and_return();
        tick();

        // Level source 1 held through return re-requests; dropped does not.
        mode_reg = 8'hFD;
        int_src = 8'h02;
        tick();
        tick();
        check("l1_vec", 32'(int_vec_addr), 32'h0002);
        accept_and_return();
        tick();
        check("l1_rereq", 32'(interrupt), 1);
        hazard_unit_state = ACC;
        tick();
        hazard_unit_state = 4'd0;
        int_src = 8'h00;
        tick();
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
        tick();
        check("l1_norereq", 32'(interrupt), 0);
        mode_reg = 8'hFF;

        // GIE dropped during REQ withdraws; restored re-requests.
        int_src = 8'h10;
        tick();
        tick();
        control_reg = 8'h00;
        tick();
        check("g_irq", 32'(interrupt), 0);
        check("g_vec", 32'(int_vec_addr), 0);
        check("g_pend", 32'(pending[4]), 1);
        control_reg = 8'h01;
        tick();
        check("g_vec2", 32'(int_vec_addr), 32'h0005);
        int_src = 8'h00;
        accept_and_return();
        tick();

        // Reset pulsed in SVC clears everything immediately.
        mask_reg = 8'hBF;
        int_src = 8'h41;
        tick();
        tick();
        hazard_unit_state = ACC;
        tick();
        hazard_unit_state = 4'd0;
        check("r_svc_pre", 32'(in_service), 1);
        #2;
        nreset = 1'b0;
        #1;
        check("r_svc", 32'(in_service), 0);
        check("r_pend", 32'(pending), 0);
        check("r_irq", 32'(interrupt), 0);
        check("r_vec", 32'(int_vec_addr), 0);
        model_reset();
        int_src = 8'h00;
        mask_reg = 8'hFF;
        @(negedge clock);
        nreset = 1'b1;

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            int_src = 8'($urandom);
            if ($urandom_range(0, 9) == 0) mode_reg = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask_reg = 8'($urandom);
            control_reg = 8'($urandom) | 8'(($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 9) == 0) control_reg[0] = 1'b0;
            hazard_unit_state = ($urandom_range(0, 2) == 0) ? ACC
                                : 4'($urandom);
            int_return = ($urandom_range(0, 4) == 0);
            pend_clear = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
